// File: rtl/updown_dir_ctrl_pkg.sv
// updown_dir_ctrl_pkg
// Shared constants for the up/down counter direction controller.
//   ST_UP / ST_DOWN   : state register encoding
//   DIR_UP / DIR_DOWN : value driven on the counter mode input m
//   DEF_*             : default counter width and sweep limits
package updown_dir_ctrl_pkg;

    localparam logic ST_UP    = 1'b1;
    localparam logic ST_DOWN  = 1'b0;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int unsigned DEF_WIDTH    = 4;
    localparam int unsigned DEF_LO_LIMIT = 0;
    localparam int unsigned DEF_HI_LIMIT = 15;

    typedef enum logic {
        StDown = ST_DOWN,
        StUp   = ST_UP
    } state_e;

endpackage

// File: rtl/updown_dir_ctrl.sv
// updown_dir_ctrl
// Direction controller for a synchronous up/down counter. Reads the counter value z back and
// drives the counter mode m. In sweep mode the counter ping-pongs between LO_LIMIT and
// HI_LIMIT (inclusive) without overshoot; in manual mode m follows dir_req one cycle later.
//
// Ports:
//   clk        rising-edge clock, shared with the counter
//   rst        synchronous active-high reset (forces UP, clears flip pulse and sweep count)
//   z          current counter value
//   sweep_en   1 = automatic sweep, 0 = manual
//   dir_req    manual direction request (1 = up)
//   m          registered counter mode (1 = up)
//   dir_flip   one-cycle pulse in the cycle following any state change
//   sweep_cnt  completed LO->HI->LO round trips, wraps modulo 2^CNT_W
//
// Build option: define UPDOWN_DIR_CTRL_SWEEP_COUNT_EN to build the sweep counter; otherwise
// sweep_cnt is tied to zero.
//
// HI_LIMIT - LO_LIMIT must be at least 2 so the two turn thresholds do not overlap.
module updown_dir_ctrl
    import updown_dir_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned LO_LIMIT = DEF_LO_LIMIT,
    parameter int unsigned HI_LIMIT = DEF_HI_LIMIT,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] z,
    input  logic             sweep_en,
    input  logic             dir_req,
    output logic             m,
    output logic             dir_flip,
    output logic [CNT_W-1:0] sweep_cnt
);

    // The counter steps with the old m on the same edge the state turns, so the turn is
    // taken one value early to land exactly on the limit.
    localparam logic [WIDTH-1:0] HI_TURN = WIDTH'(HI_LIMIT - 1);
    localparam logic [WIDTH-1:0] LO_TURN = WIDTH'(LO_LIMIT + 1);

    state_e state_q, state_d;
    logic   dir_flip_q;
    logic   state_chg;

    always_comb begin
        state_d = state_q;
        if (sweep_en) begin
            unique case (state_q)
                StUp:    if (z >= HI_TURN) state_d = StDown;
                StDown:  if (z <= LO_TURN) state_d = StUp;
                default: state_d = StUp;
            endcase
        end else begin
            state_d = (dir_req == DIR_UP) ? StUp : StDown;
        end
    end

    assign state_chg = (state_d != state_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StUp;
            dir_flip_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_flip_q <= state_chg;
        end
    end

    assign m        = (state_q == StUp) ? DIR_UP : DIR_DOWN;
    assign dir_flip = dir_flip_q;

`ifdef UPDOWN_DIR_CTRL_SWEEP_COUNT_EN
    logic [CNT_W-1:0] sweep_cnt_q, sweep_cnt_d;

    // A round trip completes on the sweep-mode turn back up at the low end.
    always_comb begin
        sweep_cnt_d = sweep_cnt_q;
        if (sweep_en && (state_q == StDown) && (state_d == StUp)) begin
            sweep_cnt_d = sweep_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_cnt_q <= '0;
        end else begin
            sweep_cnt_q <= sweep_cnt_d;
        end
    end

    assign sweep_cnt = sweep_cnt_q;
`else
    assign sweep_cnt = '0;
`endif

endmodule

// File: tb/tb_updown_dir_ctrl.sv
module tb_updown_dir_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] z;
    logic       sweep_en;
    logic       dir_req;
    logic       m;
    logic       dir_flip;
    logic [1:0] sweep_cnt;

    // Bench-side model of the existing 4-bit up/down counter, with a load for setup and an
    // override to force arbitrary z values into the controller.
    logic [3:0] cnt_q;
    logic       cnt_load;
    logic [3:0] cnt_load_val;
    logic       ovr_en;
    logic [3:0] ovr_val;

    int checks;
    int failures;

    assign z = ovr_en ? ovr_val : cnt_q;

    always @(posedge clk) begin
        if (cnt_load)  cnt_q <= cnt_load_val;
        else if (m)    cnt_q <= cnt_q + 4'd1;
        else           cnt_q <= cnt_q - 4'd1;
    end

    updown_dir_ctrl #(
        .WIDTH   (4),
        .LO_LIMIT(0),
        .HI_LIMIT(15),
        .CNT_W   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .z        (z),
        .sweep_en (sweep_en),
        .dir_req  (dir_req),
        .m        (m),
        .dir_flip (dir_flip),
        .sweep_cnt(sweep_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] cnt_exp(input int n);
`ifdef UPDOWN_DIR_CTRL_SWEEP_COUNT_EN
        cnt_exp = 2'(n);
`else
        cnt_exp = 2'd0;
`endif
    endfunction

    task automatic do_reset(input logic [3:0] zv);
        rst          = 1'b1;
        cnt_load     = 1'b1;
        cnt_load_val = zv;
        ovr_en       = 1'b0;
        tick();
        tick();
        rst      = 1'b0;
        cnt_load = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        sweep_en     = 1'b1;
        dir_req      = 1'b0;
        cnt_load     = 1'b1;
        cnt_load_val = 4'd0;
        ovr_en       = 1'b1;
        ovr_val      = 4'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (m !== 1'b1) begin
                failures++;
                $display("FAIL reset_m cyc=%0d: got %b expected 1", i, m);
            end
            checks++;
            if (dir_flip !== 1'b0) begin
                failures++;
                $display("FAIL reset_flip cyc=%0d: got %b expected 0", i, dir_flip);
            end
            checks++;
            if (sweep_cnt !== 2'd0) begin
                failures++;
                $display("FAIL reset_cnt cyc=%0d: got %0d expected 0", i, sweep_cnt);
            end
        end
        rst      = 1'b0;
        cnt_load = 1'b0;
        ovr_en   = 1'b0;
    endtask

    // Closed loop from z=0: triangle wave with period 30, four full round trips plus a bit.
    task automatic test_sweep();
        int         p;
        logic [3:0] ez;
        logic       em;
        logic       ef;
        logic [1:0] ec;
        sweep_en = 1'b1;
        do_reset(4'd0);
        for (int k = 0; k <= 125; k++) begin
            p  = k % 30;
            ez = (p <= 15) ? 4'(p) : 4'(30 - p);
            em = (p <= 14);
            ef = (k > 0) && ((p == 15) || (p == 0));
            ec = cnt_exp(k / 30);
            checks++;
            if (z !== ez) begin
                failures++;
                $display("FAIL sweep_z k=%0d: got %0d expected %0d", k, z, ez);
            end
            checks++;
            if (m !== em) begin
                failures++;
                $display("FAIL sweep_m k=%0d: got %b expected %b", k, m, em);
            end
            checks++;
            if (dir_flip !== ef) begin
                failures++;
                $display("FAIL sweep_flip k=%0d: got %b expected %b", k, dir_flip, ef);
            end
            checks++;
            if (sweep_cnt !== ec) begin
                failures++;
                $display("FAIL sweep_cnt k=%0d: got %0d expected %0d", k, sweep_cnt, ec);
            end
            tick();
        end
    endtask

    // dir_req 1,0,0,1,0 starting from UP; last step checks back-to-back flip pulses.
    task automatic test_manual();
        logic req_v [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic m_v   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic f_v   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        sweep_en = 1'b1;
        do_reset(4'd7);
        sweep_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dir_req = req_v[i];
            tick();
            checks++;
            if (m !== m_v[i]) begin
                failures++;
                $display("FAIL manual_m step=%0d: got %b expected %b", i, m, m_v[i]);
            end
            checks++;
            if (dir_flip !== f_v[i]) begin
                failures++;
                $display("FAIL manual_flip step=%0d: got %b expected %b", i, dir_flip, f_v[i]);
            end
        end
        checks++;
        if (sweep_cnt !== 2'd0) begin
            failures++;
            $display("FAIL manual_cnt: got %0d expected 0", sweep_cnt);
        end
    endtask

    // Forced z values: out-of-range convergence and the exact turn thresholds.
    task automatic test_out_of_range();
        logic [3:0] z_v [8] = '{4'd15, 4'd15, 4'd0, 4'd0, 4'd13, 4'd14, 4'd2, 4'd1};
        logic       m_v [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       f_v [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int         c_v [8] = '{0, 0, 1, 1, 1, 1, 1, 2};
        logic [1:0] ec;
        sweep_en = 1'b1;
        do_reset(4'd0);
        ovr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ovr_val = z_v[i];
            tick();
            ec = cnt_exp(c_v[i]);
            checks++;
            if (m !== m_v[i]) begin
                failures++;
                $display("FAIL oor_m step=%0d z=%0d: got %b expected %b", i, z_v[i], m, m_v[i]);
            end
            checks++;
            if (dir_flip !== f_v[i]) begin
                failures++;
                $display("FAIL oor_flip step=%0d: got %b expected %b", i, dir_flip, f_v[i]);
            end
            checks++;
            if (sweep_cnt !== ec) begin
                failures++;
                $display("FAIL oor_cnt step=%0d: got %0d expected %0d", i, sweep_cnt, ec);
            end
        end
        ovr_en = 1'b0;
    endtask

    // k=51 is on the second descent at z=9 with one round trip already counted.
    task automatic test_reset_mid_sweep();
        sweep_en = 1'b1;
        do_reset(4'd0);
        for (int k = 0; k < 51; k++) tick();
        checks++;
        if ((z !== 4'd9) || (m !== 1'b0) || (sweep_cnt !== cnt_exp(1))) begin
            failures++;
            $display("FAIL mid_pre: got z=%0d m=%b cnt=%0d expected z=9 m=0 cnt=%0d",
                     z, m, sweep_cnt, cnt_exp(1));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (m !== 1'b1) begin
            failures++;
            $display("FAIL mid_m: got %b expected 1", m);
        end
        checks++;
        if (sweep_cnt !== 2'd0) begin
            failures++;
            $display("FAIL mid_cnt: got %0d expected 0", sweep_cnt);
        end
        checks++;
        if (dir_flip !== 1'b0) begin
            failures++;
            $display("FAIL mid_flip: got %b expected 0", dir_flip);
        end
        checks++;
        if (z !== 4'd8) begin
            failures++;
            $display("FAIL mid_z0: got %0d expected 8", z);
        end
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++;
            if ((z !== 4'(8 + i)) || (m !== 1'b1)) begin
                failures++;
                $display("FAIL mid_resume i=%0d: got z=%0d m=%b expected z=%0d m=1",
                         i, z, m, 8 + i);
            end
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        sweep_en     = 1'b1;
        dir_req      = 1'b0;
        cnt_load     = 1'b1;
        cnt_load_val = 4'd0;
        ovr_en       = 1'b0;
        ovr_val      = 4'd0;
        test_reset();
        test_sweep();
        test_manual();
        test_out_of_range();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
